nukv_privacy_value_framer: RTL
==============================

Name: nukv_privacy_value_framer

Overview:
- Downstream of the privacy pipeline; consumes its merged bypass/rotation output stream, one value per last-delimited packet.
- Reads the byte-length field in each value's first word and makes the emitted packet exactly the declared number of words.
  - Short values: zero-padded.
  - Long values: excess words dropped.
- Keeps the response framer's last-word alignment correct regardless of what the rotation path produced.
- Single registered output stage; keeps per-event counters for debug.

Parameters:
- MEMORY_WIDTH, 512: data word width in bits; BYTES_PER_WORD = MEMORY_WIDTH/8.
- VALUE_SIZE_BYTES_NO, 2: width in bytes of the length field at bits [8*VALUE_SIZE_BYTES_NO-1:0] of the first word.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- input_data  in  MEMORY_WIDTH  value word from the privacy pipeline.
- input_valid  in  1  input word valid.
- input_last  in  1  last word of the input value.
- input_ready  out  1  input word accepted when valid&ready.
- output_data  out  MEMORY_WIDTH  framed value word.
- output_valid  out  1  output word valid.
- output_last  out  1  last word of the framed value.
- output_ready  in  1  downstream ready.
- cnt_values  out  CNT_WIDTH  number of values fully emitted.
- cnt_padded  out  CNT_WIDTH  number of values that needed padding.
- cnt_truncated  out  CNT_WIDTH  number of values that had words dropped.

Behaviour:
- Reset (rst=0, async):
  - state=HEAD, output register empty.
  - output_valid=0, output_last=0, output_data=0, all counters=0, remaining=0.
- Output register:
  - One entry.
  - Loadable when empty or output_ready=1 (reg_free).
  - Holds data/last stable while output_valid=1 and output_ready=0.
  - Input-to-output latency is 1 cycle.
- input_ready:
  - reg_free in HEAD/BODY.
  - 0 in PAD.
  - 1 in DROP.
- Length computation (HEAD only):
  - L = first word bits [8*VALUE_SIZE_BYTES_NO-1:0].
  - W = ceil(L/BYTES_PER_WORD), with W forced to 1 when L=0.
  - remaining counter is 8*VALUE_SIZE_BYTES_NO+1 bits wide; no overflow possible.
- HEAD, on input handshake: forward the word, then:
  - W=1 and input_last=1: output_last=1, stay HEAD.
  - W=1 and input_last=0: output_last=1, go DROP, cnt_truncated+1.
  - W>1 and input_last=1: output_last=0, remaining=W-1, go PAD, cnt_padded+1.
  - W>1 and input_last=0: output_last=0, remaining=W-1, go BODY.
- BODY, on input handshake: forward the word, then:
  - remaining=1 and input_last=1: output_last=1, go HEAD.
  - remaining=1 and input_last=0: output_last=1, go DROP, cnt_truncated+1.
  - remaining>1 and input_last=1: output_last=0, remaining-1, go PAD, cnt_padded+1.
  - Otherwise: remaining-1, stay.
- PAD, each cycle with reg_free: load an all-zero word and decrement remaining. When remaining=1, set output_last=1 and go HEAD.
- DROP: consume input words with no output; on input_last go HEAD.
- Counters and wrap:
  - cnt_values increments when a word with output_last=1 is loaded into the output register.
  - All counters wrap at 2^CNT_WIDTH.
- Ordering: exactly one framed packet per input packet; order preserved.
- Simultaneous load and unload in the same cycle is legal and sustains full throughput (1 word/cycle) in HEAD/BODY/PAD.
- Reset mid-packet: the partial output is discarded, with output_valid low immediately. The upstream partial packet is not resynchronised; the next word seen is treated as a head.

Test Plan:
- L=128, two input words, input_last on word 2, output_ready=1 -> two identical output words one cycle later, output_last on word 2, cnt_values=1.
- L=200 (W=4), two input words -> outputs: word1, word2, then 2 zero words; output_last on word 4 only; input_ready=0 during the 2 pad cycles; cnt_padded=1.
- L=64, three input words -> one output word with output_last=1; words 2-3 consumed with input_ready=1 and no output; cnt_truncated=1.
- L=0, single-word value; then L=1, single-word value back-to-back -> two outputs on consecutive cycles, each with output_last=1, cnt_values=2.
- L=256 (W=4) streaming, output_ready held low 5 cycles after word 2 -> output_data/output_last stable across the stall, input_ready=0, no word lost or duplicated, 4 words total.
- rst asserted low during PAD of the W=4 case -> output_valid=0 and counters=0 asynchronously; after release, an L=64 single-word value passes with output_last=1.

Source files
------------

// File: rtl/nukv_privacy_value_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// nukv_privacy_value_framer: frames each value to its declared word count.
// Revision: 1.0
// ============================================================================
module nukv_privacy_value_framer #(
  parameter int MEMORY_WIDTH        = 512,
  parameter int VALUE_SIZE_BYTES_NO = 2,
  parameter int CNT_WIDTH           = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MEMORY_WIDTH-1:0] input_data,
  input  logic                    input_valid,
  input  logic                    input_last,
  output logic                    input_ready,
  output logic [MEMORY_WIDTH-1:0] output_data,
  output logic                    output_valid,
  output logic                    output_last,
  input  logic                    output_ready,
  output logic [CNT_WIDTH-1:0]    cnt_values,
  output logic [CNT_WIDTH-1:0]    cnt_padded,
  output logic [CNT_WIDTH-1:0]    cnt_truncated
);

  localparam int BYTES_PER_WORD = MEMORY_WIDTH / 8;
  localparam int LEN_W          = 8 * VALUE_SIZE_BYTES_NO;
  localparam int REM_W          = LEN_W + 1;

  typedef enum logic [1:0] {
    S_HEAD = 2'd0,
    S_BODY = 2'd1,
    S_PAD  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic [MEMORY_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [CNT_WIDTH-1:0]    values_q, values_d;
  logic [CNT_WIDTH-1:0]    padded_q, padded_d;
  logic [CNT_WIDTH-1:0]    trunc_q, trunc_d;

  logic             reg_free;
  logic             in_hs;
  logic             load;
  logic [REM_W-1:0] len_ext;
  logic [REM_W-1:0] words_ceil;
  logic [REM_W-1:0] words;

  assign reg_free = ~valid_q | output_ready;

  always_comb begin
    case (state_q)
      S_HEAD, S_BODY: input_ready = reg_free;
      S_PAD:          input_ready = 1'b0;
      default:        input_ready = 1'b1;
    endcase
  end

  assign in_hs = input_valid & input_ready;

  // A zero-length value still occupies one word so the framer sees a packet.
  assign len_ext    = REM_W'(input_data[LEN_W-1:0]);
  assign words_ceil = (len_ext + REM_W'(BYTES_PER_WORD - 1)) / REM_W'(BYTES_PER_WORD);
  assign words      = (len_ext == '0) ? REM_W'(1) : words_ceil;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    data_d   = data_q;
    last_d   = last_q;
    valid_d  = valid_q & ~output_ready;
    values_d = values_q;
    padded_d = padded_q;
    trunc_d  = trunc_q;
    load     = 1'b0;
    case (state_q)
      S_HEAD: begin
        if (in_hs) begin
          load   = 1'b1;
          data_d = input_data;
          if (words == REM_W'(1)) begin
            last_d = 1'b1;
            if (!input_last) begin
              state_d = S_DROP;
              trunc_d = trunc_q + CNT_WIDTH'(1);
            end
          end else begin
            last_d = 1'b0;
            rem_d  = words - REM_W'(1);
            if (input_last) begin
              state_d  = S_PAD;
              padded_d = padded_q + CNT_WIDTH'(1);
            end else begin
              state_d = S_BODY;
            end
          end
        end
      end
      S_BODY: begin
        if (in_hs) begin
          load   = 1'b1;
          data_d = input_data;
          if (rem_q == REM_W'(1)) begin
            last_d  = 1'b1;
            state_d = input_last ? S_HEAD : S_DROP;
            if (!input_last) trunc_d = trunc_q + CNT_WIDTH'(1);
          end else begin
            last_d = 1'b0;
            rem_d  = rem_q - REM_W'(1);
            if (input_last) begin
              state_d  = S_PAD;
              padded_d = padded_q + CNT_WIDTH'(1);
            end
          end
        end
      end
      S_PAD: begin
        if (reg_free) begin
          load   = 1'b1;
          data_d = '0;
          rem_d  = rem_q - REM_W'(1);
          last_d = (rem_q == REM_W'(1));
          if (rem_q == REM_W'(1)) state_d = S_HEAD;
        end
      end
      default: begin
        if (in_hs && input_last) state_d = S_HEAD;
      end
    endcase
    if (load) begin
      valid_d = 1'b1;
      if (last_d) values_d = values_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_HEAD;
      rem_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      values_q <= '0;
      padded_q <= '0;
      trunc_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      values_q <= values_d;
      padded_q <= padded_d;
      trunc_q  <= trunc_d;
    end
  end

  assign output_data   = data_q;
  assign output_valid  = valid_q;
  assign output_last   = last_q;
  assign cnt_values    = values_q;
  assign cnt_padded    = padded_q;
  assign cnt_truncated = trunc_q;

endmodule
`default_nettype wire
